// File: rtl/sd_block_cache.sv
// sd_block_cache: single-block read cache in front of sd_controller.
// Holds one 512-byte SD block plus its tag and answers 32-bit word reads
// from it; a miss issues one CMD17 block read through the controller's
// rd_en/addr/busy handshake and answers from the freshly filled block.
// Optional build macro SD_CACHE_WRITE_ERR_EN: writes answer with err_o
// instead of being acked and discarded.
module sd_block_cache #(
    parameter int TAG_W = 23
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cyc_i,
    input  logic          stb_i,
    input  logic          we_i,
    input  logic [31:0]   addr_i,
    output logic [31:0]   rd_data_o,
    output logic          ack_o,
    output logic          err_o,
    input  logic          flush_i,
    output logic          sd_rd_en,
    output logic [31:0]   sd_addr,
    input  logic          sd_busy,
    input  logic [4095:0] sd_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REQ,
        S_WAIT,
        S_FILL,
        S_RESP
    } state_t;

    state_t         state_q;
    logic [4095:0]  line_q;
    logic [TAG_W-1:0] tag_q;
    logic           valid_q;
    logic           flush_pend_q;
    logic [31:2]    req_addr_q;     // byte offset within the word is ignored
    logic           req_we_q;
    logic           ack_q;
    logic [31:0]    rd_data_q;
    logic           sd_rd_en_q;
    logic [31:0]    sd_addr_q;

    logic           hit_d;
    logic [31:0]    word_d;
    logic           resp_pending;
    logic           unused_addr_lsbs;

`ifdef SD_CACHE_WRITE_ERR_EN
    logic           err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign rd_data_o        = rd_data_q;
    assign ack_o            = ack_q;
    assign sd_rd_en         = sd_rd_en_q;
    assign sd_addr          = sd_addr_q;
    assign resp_pending     = ack_q | err_o;
    assign unused_addr_lsbs = ^addr_i[1:0];

    // Tag compare and word select for the captured request.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        hit_d  = 1'b0;
        word_d = '0;
        hit_d  = valid_q && (tag_q == req_addr_q[9 +: TAG_W]);
        word_d = line_q[{req_addr_q[8:2], 5'd0} +: 32];
    end

    // Block data: loaded only on a fill, never reset.
    always_ff @(posedge clock) begin
        // NOTE: the 4096-bit line is deliberately left out of reset; valid_q
        // gates every use of it, so clearing it would only cost reset fanout.
        if (state_q == S_FILL) begin
            line_q <= sd_read_data;
        end
    end

    // Control FSM with registered bus and controller outputs.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= S_IDLE;
            tag_q        <= '0;
            valid_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            req_addr_q   <= '0;
            req_we_q     <= 1'b0;
            ack_q        <= 1'b0;
            rd_data_q    <= '0;
            sd_rd_en_q   <= 1'b0;
            sd_addr_q    <= '0;
`ifdef SD_CACHE_WRITE_ERR_EN
            err_q        <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef SD_CACHE_WRITE_ERR_EN
            err_q <= 1'b0;
`endif
            if (flush_i) begin
                flush_pend_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    // A flush while idle takes effect at once.
                    if (flush_i) begin
                        valid_q      <= 1'b0;
                        flush_pend_q <= 1'b0;
                    end
                    if (cyc_i && stb_i && !resp_pending) begin
                        req_addr_q <= addr_i[31:2];
                        req_we_q   <= we_i;
                        state_q    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (req_we_q || hit_d) begin
                        state_q <= S_RESP;
                    end else begin
                        sd_addr_q  <= {9'b0, req_addr_q[31:9]};
                        sd_rd_en_q <= 1'b1;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (sd_busy) begin
                        sd_rd_en_q <= 1'b0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!sd_busy) begin
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    tag_q   <= req_addr_q[9 +: TAG_W];
                    valid_q <= 1'b1;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (req_we_q) begin
`ifdef SD_CACHE_WRITE_ERR_EN
                        err_q <= cyc_i;
`else
                        ack_q <= cyc_i;
`endif
                    end else begin
                        ack_q     <= cyc_i;
                        rd_data_q <= word_d;
                    end
                    // Entering IDLE: apply any flush seen during this request.
                    if (flush_pend_q || flush_i) begin
                        valid_q      <= 1'b0;
                        flush_pend_q <= 1'b0;
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_cache.sv
// tb_sd_block_cache: directed bench for sd_block_cache with a scoreboard.
// A small sd_controller model answers block reads with a pattern whose
// word i is 0xA5000000 + (fill_number << 16) + i, so every fill is distinct.
module tb_sd_block_cache;

    typedef struct {
        string       name;
        logic [1:0]  kind;   // {err, ack}
        logic [31:0] data;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          cyc_i;
    logic          stb_i;
    logic          we_i;
    logic [31:0]   addr_i;
    logic [31:0]   rd_data_o;
    logic          ack_o;
    logic          err_o;
    logic          flush_i;
    logic          sd_rd_en;
    logic [31:0]   sd_addr;
    logic          sd_busy;
    logic [4095:0] sd_read_data;

    exp_t          sb[$];
    int            tests_run;
    int            tests_failed;
    int            rd_en_pulses;
    int            fill_cnt;
    logic [31:0]   last_sd_addr;
    logic          rd_en_prev;

    sd_block_cache #(.TAG_W(23)) dut (
        .clock        (clock),
        .reset        (reset),
        .cyc_i        (cyc_i),
        .stb_i        (stb_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .rd_data_o    (rd_data_o),
        .ack_o        (ack_o),
        .err_o        (err_o),
        .flush_i      (flush_i),
        .sd_rd_en     (sd_rd_en),
        .sd_addr      (sd_addr),
        .sd_busy      (sd_busy),
        .sd_read_data (sd_read_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Controller model: one block read per sampled rd_en, busy for 5 cycles.
    initial begin
        sd_busy      = 1'b0;
        sd_read_data = '0;
        fill_cnt     = 0;
        last_sd_addr = '0;
        forever begin
            @(negedge clock);
            if (!reset && sd_rd_en && !sd_busy) begin
                last_sd_addr = sd_addr;
                @(negedge clock);
                sd_busy = 1'b1;
                repeat (5) @(negedge clock);
                for (int i = 0; i < 128; i++) begin
                    sd_read_data[32*i +: 32] = 32'hA500_0000 + (32'(fill_cnt) << 16) + 32'(i);
                end
                fill_cnt++;
                sd_busy = 1'b0;
            end
        end
    end

    // Count rising edges of sd_rd_en.
    initial begin
        rd_en_pulses = 0;
        rd_en_prev   = 1'b0;
        forever begin
            @(negedge clock);
            if (sd_rd_en && !rd_en_prev) rd_en_pulses++;
            rd_en_prev = sd_rd_en;
        end
    end

    // Monitor: every response pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && (ack_o || err_o)) begin
                if (sb.size() == 0) begin
                    check("unexpected_response", {30'b0, err_o, ack_o}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_kind"}, {30'b0, err_o, ack_o}, {30'b0, e.kind});
                    check({e.name, "_data"}, rd_data_o, e.data);
                end
            end
        end
    end

    // mode 0: plain request, 1: flush pulse during WAIT, 2: drop cyc during WAIT
    task automatic do_req(input string name, input logic [31:0] addr, input logic we,
                          input logic miss, input logic [31:0] exp_data, input int mode);
        exp_t e;
        int   p0;
        int   n;
        bit   got;
        p0 = rd_en_pulses;
        if (mode != 2) begin
            e.name = name;
`ifdef SD_CACHE_WRITE_ERR_EN
            e.kind = we ? 2'b10 : 2'b01;
`else
            e.kind = 2'b01;
`endif
            e.data = exp_data;
            sb.push_back(e);
        end
        @(negedge clock);
        cyc_i  = 1'b1;
        stb_i  = 1'b1;
        addr_i = addr;
        we_i   = we;
        @(negedge clock);
        stb_i = 1'b0;
        n     = 1;
        got   = 1'b0;
        if (mode != 0) begin
            for (int k = 0; k < 50 && !sd_busy; k++) @(negedge clock);
            check({name, "_busy_seen"}, {31'b0, sd_busy}, 32'h1);
            @(negedge clock);
            if (mode == 1) begin
                flush_i = 1'b1;
                @(negedge clock);
                flush_i = 1'b0;
            end else begin
                cyc_i = 1'b0;
                for (int k = 0; k < 50 && sd_busy; k++) @(negedge clock);
                repeat (8) @(negedge clock);
                got = 1'b1;
            end
        end
        if (mode != 2) begin
            while (n < 200 && !(ack_o || err_o)) begin
                @(negedge clock);
                n++;
            end
            got = ack_o || err_o;
            if (!miss) check({name, "_latency"}, 32'(n), 32'd3);
        end
        check({name, "_responded"}, {31'b0, got}, 32'h1);
        cyc_i = 1'b0;
        we_i  = 1'b0;
        @(negedge clock);
        check({name, "_rd_en_pulses"}, 32'(rd_en_pulses - p0), miss ? 32'd1 : 32'd0);
        if (miss) check({name, "_sd_addr"}, last_sd_addr, {9'b0, addr[31:9]});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b1;
        cyc_i   = 1'b0;
        stb_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = '0;
        flush_i = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_ack", {31'b0, ack_o}, 32'h0);
        check("reset_err", {31'b0, err_o}, 32'h0);
        check("reset_rd_data", rd_data_o, 32'h0);
        check("reset_sd_rd_en", {31'b0, sd_rd_en}, 32'h0);
        check("reset_sd_addr", sd_addr, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        do_req("miss_204",      32'h0000_0204, 1'b0, 1'b1, 32'hA500_0001, 0);
        do_req("hit_3fc",       32'h0000_03FC, 1'b0, 1'b0, 32'hA500_007F, 0);
        do_req("miss_400",      32'h0000_0400, 1'b0, 1'b1, 32'hA501_0000, 0);
        do_req("remiss_204",    32'h0000_0204, 1'b0, 1'b1, 32'hA502_0001, 0);
        do_req("flush_600",     32'h0000_0600, 1'b0, 1'b1, 32'hA503_0000, 1);
        do_req("after_flush",   32'h0000_0600, 1'b0, 1'b1, 32'hA504_0000, 0);
        do_req("drop_800",      32'h0000_0800, 1'b0, 1'b1, 32'h0,         2);
        do_req("hit_804",       32'h0000_0804, 1'b0, 1'b0, 32'hA505_0001, 0);
        do_req("write_10",      32'h0000_0010, 1'b1, 1'b0, 32'hA505_0001, 0);
        do_req("hit_80c",       32'h0000_080C, 1'b0, 1'b0, 32'hA505_0003, 0);

        repeat (4) @(negedge clock);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sd_block_cache.md
# sd_block_cache

Single-block read cache between the CPU data bus and `sd_controller`. It holds one 512-byte SD block (4096 bits) with its block tag and serves 32-bit word reads from it. On a miss it issues one CMD17 request through the controller's `rd_en`/`addr`/`busy` handshake, latches the returned `read_data` block and then answers the CPU. This block is the pseudocache that drives the controller's pseudocache interface.

## Interface
Parameters:
- `TAG_W`, 23, block-tag width; equals address bits [31:9].

Ports:
- `clock` in 1: single clock for the whole block; the `sd_controller` handshake signals are synchronous to it.
- `reset` in 1: asynchronous, active-high.
- `cyc_i` in 1: bus cycle active.
- `stb_i` in 1: request strobe.
- `we_i` in 1: write request (SD is read-only).
- `addr_i` in 32: byte address.
- `rd_data_o` out 32: read word.
- `ack_o` out 1: one-cycle response pulse.
- `err_o` out 1: one-cycle error pulse; used only with `SD_CACHE_WRITE_ERR_EN`, otherwise tied 0.
- `flush_i` in 1: invalidate the cached block.
- `sd_rd_en` out 1: to controller `rd_en`.
- `sd_addr` out 32: to controller `addr`; value is `{9'b0, addr_i[31:9]}` (SDHC block number).
- `sd_busy` in 1: from controller `busy`.
- `sd_read_data` in 4096: from controller `read_data`.

## Operation
- Stored state: `line[4095:0]`, `tag[TAG_W-1:0]`, `valid`, `flush_pend`, and the captured request address `req_addr`.
- Word select: `w = req_addr[8:2]`. The word is `line[32*w +: 32]`. `addr_i[1:0]` is ignored.
- FSM states: IDLE, LOOKUP, REQ, WAIT, FILL, RESP.
- IDLE: when `cyc_i & stb_i & ~ack_o & ~err_o`, capture `addr_i` and `we_i`, then go to LOOKUP.
- LOOKUP, write request: go to RESP. The write is acked and discarded, or errored with the macro.
- LOOKUP, read hit (`valid` and `tag == req_addr[31:9]`): go to RESP.
- LOOKUP, read miss: go to REQ.
- REQ: drive `sd_rd_en=1` and a stable `sd_addr`. Hold until `sd_busy=1` is sampled, then go to WAIT.
- WAIT: `sd_rd_en=0`. Go to FILL when `sd_busy=0` is sampled.
- FILL: `line<=sd_read_data`, `tag<=req_addr[31:9]`, `valid<=1`, then go to RESP.
- RESP: `rd_data_o` is registered from `line`. Pulse `ack_o` (or `err_o`) for one cycle only if `cyc_i` is still high; a dropped cycle gets no response. Then go to IDLE.
- Flush: a `flush_i` pulse in any state sets `flush_pend`. On entry to IDLE, `valid<=0` and `flush_pend<=0`. A miss in flight therefore still completes and answers from its fresh data.
- Reset mid-miss: all state clears immediately and `sd_rd_en` drops. The controller finishes its transfer independently; a later request re-issues it.

## Timing
- Reset values: `ack_o=0`, `err_o=0`, `rd_data_o=0`, `sd_rd_en=0`, `sd_addr=0`, `valid=0`, `flush_pend=0`, state IDLE.
- Hit latency: request sampled at cycle 0; `ack_o` high in cycle 3 (IDLE→LOOKUP→RESP, output registered).
- Miss latency: 4 cycles plus controller busy time. `ack_o` is high 2 cycles after `sd_busy` is sampled low.
- `sd_rd_en` high for at least 1 cycle and at most until the first `sd_busy=1` sample.
- Back-to-back requests: a new strobe is accepted only in IDLE with `ack_o=0`, so at most one request per 4 cycles.
- `rd_data_o` holds its value after `ack_o` until the next RESP.

## Configuration
- `SD_CACHE_WRITE_ERR_EN` defined: a write request answers with `err_o` for one cycle; `ack_o` stays 0 and cache state is unchanged.
- `SD_CACHE_WRITE_ERR_EN` undefined: a write request is acked with `ack_o` and `rd_data_o` unchanged; `err_o` is constant 0.

## Test plan
- Reset, then read `addr_i=0x0000_0204`; model returns a block with word i = `0xA500_0000+i`. Required: one `sd_rd_en` pulse with `sd_addr=0x1`, then `ack_o` pulse with `rd_data_o=0xA500_0001`.
- Reread `0x0000_03FC` after the above. Required: no `sd_rd_en`, `ack_o` in cycle 3, `rd_data_o=0xA500_007F`.
- Read `0x0000_0400`. Required: miss with `sd_addr=0x2`; tag replaced; a following read of `0x204` misses again.
- Pulse `flush_i` during WAIT of a miss. Required: that request acks with fresh data; the next read of the same address misses.
- Drop `cyc_i` during WAIT. Required: fill completes, no `ack_o`; the next read of that block hits.
- Write to `0x10`. Required: `ack_o` without the macro; `err_o` with `SD_CACHE_WRITE_ERR_EN`. In both cases no `sd_rd_en` and cached data unchanged.
